// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back, write-allocate L1 data cache controller
module dcache_controller #(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(LINE_BITS / 8);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, REFILL} state_t;

  state_t               state;
  logic [NUM_SETS-1:0]  valid, dirty;
  logic [TAG_W-1:0]     tags  [NUM_SETS];
  logic [LINE_BITS-1:0] lines [NUM_SETS];
  logic [TAG_W-1:0]     tag, miss_tag;
  logic [IDX_W-1:0]     idx, miss_idx;
  logic [OFF_W-3:0]     word;
  logic                 hit, victim_dirty, unused_addr;

  assign tag          = cpu_addr_i[31 -: TAG_W];
  assign idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign word         = cpu_addr_i[OFF_W-1:2];
  assign unused_addr  = ^cpu_addr_i[1:0];
  assign hit          = cpu_req_i & valid[idx] & (tags[idx] == tag);
  assign victim_dirty = valid[idx] & dirty[idx];
  assign cpu_data_o   = hit ? lines[idx][{word, 5'b0} +: 32] : 32'h0;
  // Reset forces the stall low so the pipeline is released while reset is held.
  assign cpu_stall_o  = rst_i & ((state != IDLE) | (cpu_req_i & ~hit));

  // Miss sequencer: owns valid/dirty bits, the latched miss address and the registered memory port.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      miss_tag     <= '0;
      miss_idx     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            miss_tag     <= tag;
            miss_idx     <= idx;
            mem_enable_o <= 1'b1;
            mem_write_o  <= victim_dirty;
            mem_addr_o   <= {victim_dirty ? tags[idx] : tag, idx, {OFF_W{1'b0}}};
            mem_data_o   <= lines[idx];
            state        <= victim_dirty ? WRITEBACK : FETCH;
          end else if (hit && cpu_write_i) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            mem_enable_o    <= 1'b0;
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            state           <= REFILL;
          end
        end
        REFILL: state <= IDLE;
      endcase
    end
  end

  // Tag and line storage: refill on fetch ack, word merge on a store hit.
  always_ff @(posedge clk_i) begin
    if (state == FETCH && mem_ack_i) begin
      tags[miss_idx]  <= miss_tag;
      lines[miss_idx] <= mem_data_i;
    end else if (state == IDLE && hit && cpu_write_i) begin
      lines[idx][{word, 5'b0} +: 32] <= cpu_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed checks of hits, clean/dirty misses, store merge and reset abort
module tb_dcache_controller;
  logic         clk_i = 1'b0, rst_i = 1'b0;
  logic         cpu_req_i = 1'b0, cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0, cpu_data_i = '0, cpu_data_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  int tests = 0, fails = 0;
  int lat = 10, cnt = 0;
  bit resp_en = 1'b1;
  logic [255:0] mem_model [int unsigned];
  logic [31:0]  log_addr [$];
  logic         log_wr [$];
  logic [255:0] log_data [$];
  logic [288:0] prev;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] pat(input logic [31:0] a, input int i);
    return 32'hC0DE_0000 ^ (a + 32'(i * 4));
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = pat(a, i);
    return l;
  endfunction

  // Memory responder: ack after lat cycles of request, checks request stability while waiting.
  always @(posedge clk_i) begin
    #1;
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      cnt = 0;
    end
    if (resp_en && mem_enable_o) begin
      if (cnt > 0) begin
        tests++;
        if ({mem_write_o, mem_addr_o, mem_data_o} !== prev) begin
          fails++;
          $display("FAIL mem_stable: got wr=%b addr=%h want wr=%b addr=%h", mem_write_o, mem_addr_o, prev[288], prev[287:256]);
        end
      end
      prev = {mem_write_o, mem_addr_o, mem_data_o};
      cnt++;
      if (cnt == lat) begin
        log_addr.push_back(mem_addr_o);
        log_wr.push_back(mem_write_o);
        log_data.push_back(mem_data_o);
        if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
        else mem_data_i = model_line(mem_addr_o);
        mem_ack_i = 1'b1;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    cpu_req_i = 1'b1; cpu_write_i = w; cpu_addr_i = a; cpu_data_i = d;
    stalls = 0;
    @(negedge clk_i);
    while (cpu_stall_o && stalls < 300) begin
      stalls++;
      @(negedge clk_i);
    end
    rd = cpu_data_o;
    @(posedge clk_i); #2;
    cpu_req_i = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_wr.delete(); log_data.delete();
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    tests++;
    if ({cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, cpu_data_o} !== '0 || mem_data_o !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got stall=%b en=%b wr=%b addr=%h data=%h want all zero", cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, cpu_data_o);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #2;
  endtask

  task automatic test_clean_miss();
    int s; logic [31:0] rd;
    clear_log(); lat = 10;
    access(1'b0, 32'h40, 32'h0, s, rd);
    tests++; if (s !== 12) begin fails++; $display("FAIL clean_miss_stall: got %0d want 12", s); end
    tests++; if (rd !== pat(32'h40, 0)) begin fails++; $display("FAIL clean_miss_data: got %h want %h", rd, pat(32'h40, 0)); end
    tests++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h40 || log_wr[0] !== 1'b0) begin
      fails++; $display("FAIL clean_miss_req: got n=%0d want one fetch of 00000040", log_addr.size());
    end
    access(1'b0, 32'h44, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== pat(32'h40, 1)) begin fails++; $display("FAIL hit_44: got stall=%0d data=%h want 0 %h", s, rd, pat(32'h40, 1)); end
  endtask

  task automatic test_store_hit();
    int s; logic [31:0] rd;
    access(1'b1, 32'h48, 32'hDEADBEEF, s, rd);
    tests++; if (s !== 0) begin fails++; $display("FAIL store_hit_stall: got %0d want 0", s); end
    access(1'b0, 32'h48, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL store_hit_read: got stall=%0d data=%h want 0 deadbeef", s, rd); end
  endtask

  task automatic test_dirty_miss();
    int s; logic [31:0] rd;
    clear_log(); lat = 10;
    access(1'b0, 32'h240, 32'h0, s, rd);
    tests++; if (s !== 22) begin fails++; $display("FAIL dirty_miss_stall: got %0d want 22", s); end
    tests++;
    if (log_addr.size() != 2 || log_wr[0] !== 1'b1 || log_addr[0] !== 32'h40 || log_data[0][95:64] !== 32'hDEADBEEF || log_data[0][31:0] !== pat(32'h40, 0)) begin
      fails++; $display("FAIL dirty_miss_wb: got n=%0d want writeback of 00000040 with word2 deadbeef", log_addr.size());
    end
    tests++;
    if (log_addr.size() != 2 || log_wr[1] !== 1'b0 || log_addr[1] !== 32'h240) begin
      fails++; $display("FAIL dirty_miss_fetch: got n=%0d want fetch of 00000240", log_addr.size());
    end
    tests++; if (rd !== pat(32'h240, 0)) begin fails++; $display("FAIL dirty_miss_data: got %h want %h", rd, pat(32'h240, 0)); end
  endtask

  task automatic test_store_miss();
    int s; logic [31:0] rd;
    clear_log(); lat = 3;
    access(1'b1, 32'h80, 32'h12345678, s, rd);
    tests++; if (s !== 5) begin fails++; $display("FAIL store_miss_stall: got %0d want 5", s); end
    tests++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h80 || log_wr[0] !== 1'b0) begin
      fails++; $display("FAIL store_miss_fetch: got n=%0d want one fetch of 00000080", log_addr.size());
    end
    clear_log();
    access(1'b0, 32'h280, 32'h0, s, rd);
    tests++; if (s !== 8) begin fails++; $display("FAIL evict_stall: got %0d want 8", s); end
    tests++;
    if (log_addr.size() != 2 || log_wr[0] !== 1'b1 || log_addr[0] !== 32'h80 || log_data[0][31:0] !== 32'h12345678 || log_data[0][63:32] !== pat(32'h80, 1)) begin
      fails++; $display("FAIL evict_wb: got n=%0d want writeback of 00000080 word0 12345678", log_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int s; logic [31:0] rd;
    lat = 4;
    access(1'b0, 32'h240, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== pat(32'h240, 0)) begin fails++; $display("FAIL b2b_hit_a: got stall=%0d data=%h want 0 %h", s, rd, pat(32'h240, 0)); end
    access(1'b0, 32'h284, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== pat(32'h280, 1)) begin fails++; $display("FAIL b2b_hit_b: got stall=%0d data=%h want 0 %h", s, rd, pat(32'h280, 1)); end
    access(1'b0, 32'h44, 32'h0, s, rd);
    tests++; if (s !== 6 || rd !== pat(32'h40, 1)) begin fails++; $display("FAIL alt_miss_44: got stall=%0d data=%h want 6 %h", s, rd, pat(32'h40, 1)); end
    access(1'b0, 32'h48, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL alt_hit_48: got stall=%0d data=%h want 0 deadbeef", s, rd); end
    access(1'b0, 32'h88, 32'h0, s, rd);
    tests++; if (s !== 6 || rd !== pat(32'h80, 2)) begin fails++; $display("FAIL alt_miss_88: got stall=%0d data=%h want 6 %h", s, rd, pat(32'h80, 2)); end
    access(1'b0, 32'h80, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== 32'h12345678) begin fails++; $display("FAIL alt_hit_80: got stall=%0d data=%h want 0 12345678", s, rd); end
  endtask

  task automatic test_spurious_ack();
    int s; logic [31:0] rd, a0;
    a0 = mem_addr_o;
    mem_ack_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    tests++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_addr_o !== a0) begin
      fails++; $display("FAIL spurious_ack: got en=%b stall=%b addr=%h want 0 0 %h", mem_enable_o, cpu_stall_o, mem_addr_o, a0);
    end
    @(posedge clk_i); #2;
    access(1'b0, 32'h48, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL spurious_hit: got stall=%0d data=%h want 0 deadbeef", s, rd); end
  endtask

  task automatic test_reset_mid_fetch();
    int s; logic [31:0] rd;
    resp_en = 1'b0;
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h140;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    tests++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h140 || cpu_stall_o !== 1'b1) begin
      fails++; $display("FAIL fetch_pending: got en=%b wr=%b addr=%h stall=%b want 1 0 00000140 1", mem_enable_o, mem_write_o, mem_addr_o, cpu_stall_o);
    end
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    tests++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      fails++; $display("FAIL reset_abort: got en=%b stall=%b want 0 0", mem_enable_o, cpu_stall_o);
    end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    mem_ack_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    tests++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      fails++; $display("FAIL late_ack: got en=%b stall=%b want 0 0", mem_enable_o, cpu_stall_o);
    end
    resp_en = 1'b1; lat = 10; clear_log();
    @(posedge clk_i); #2;
    access(1'b0, 32'h40, 32'h0, s, rd);
    tests++; if (s !== 12 || rd !== pat(32'h40, 0)) begin fails++; $display("FAIL remiss_40: got stall=%0d data=%h want 12 %h", s, rd, pat(32'h40, 0)); end
    tests++;
    if (log_addr.size() != 1 || log_wr[0] !== 1'b0 || log_addr[0] !== 32'h40) begin
      fails++; $display("FAIL remiss_req: got n=%0d want one fetch of 00000040", log_addr.size());
    end
    access(1'b0, 32'h48, 32'h0, s, rd);
    tests++; if (s !== 0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL remiss_hit_48: got stall=%0d data=%h want 0 deadbeef", s, rd); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_store_hit();
    test_dirty_miss();
    test_store_miss();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller between the MEM pipeline stage and off-chip data memory.
- Owns the tag/valid/dirty arrays and line storage.
- Serves lw/sw hits with zero added latency and stalls the pipeline while it runs the write-back and refill sequence on a miss.
- Sequences the shared memory port so that only one transaction is outstanding at a time.

Parameters:
- NUM_SETS, 16, number of cache lines (power of two); index width IDX_W = log2(NUM_SETS) = 4.
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width = 5.
- TAG_W, 23, tag width = 32 - IDX_W - 5.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- cpu_req_i  in  1  MEM-stage access valid (lw or sw).
- cpu_write_i  in  1  1 = sw, 0 = lw.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored (word aligned).
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid when cpu_req_i=1, cpu_write_i=0 and cpu_stall_o=0.
- cpu_stall_o  out  1  freeze the whole pipeline.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address (bits [4:0] = 0).
- mem_data_o  out  256  write-back line.
- mem_data_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
- hit = cpu_req_i & valid[index] & (tag_array[index] == tag).
- Outputs at reset (rst_i low):
  - all valid and dirty bits cleared; state = IDLE;
  - cpu_stall_o = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, cpu_data_o = 0.
- Read hit: cpu_data_o = selected word of line, combinational; cpu_stall_o = 0.
- Write hit: on the clock edge, the selected word is replaced with cpu_data_i and dirty[index] is set to 1; cpu_stall_o = 0.
- Miss in IDLE: cpu_stall_o = 1 combinationally in the same cycle.
  - On the next edge, go to WRITEBACK if valid & dirty for the victim line, otherwise to FETCH.
- States:
  - IDLE: serves hits as above.
  - WRITEBACK:
    - drive mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim_tag, index, 5'b0}, mem_data_o = victim line;
    - hold all of these stable until mem_ack_i, then go to FETCH.
  - FETCH:
    - drive mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0};
    - hold until mem_ack_i; on the ack edge capture mem_data_i into the line, set valid = 1, dirty = 0, write the tag, then go to REFILL.
  - REFILL:
    - one cycle with mem_enable_o = 0 and cpu_stall_o = 1, then go to IDLE;
    - in IDLE the access re-looks-up and hits. A miss store merges its word via the normal write-hit path and sets dirty.
- cpu_stall_o = 1 in every state other than IDLE. In IDLE it equals cpu_req_i & ~hit.
- mem_enable_o is asserted only in WRITEBACK and FETCH. It deasserts in the cycle after the ack.
- mem_ack_i outside WRITEBACK/FETCH is ignored.
- The CPU holds cpu_req_i, cpu_addr_i, cpu_write_i and cpu_data_i stable while cpu_stall_o = 1. The controller latches the miss address at IDLE exit and uses the latched copy.
- Back-to-back hits on consecutive cycles are allowed with no bubbles.
- cpu_req_i = 0: no state change and no array writes.
- Reset mid-miss: the FSM returns to IDLE immediately and the memory request drops the same cycle.
  - An in-flight ack after reset is ignored.
  - Line contents are don't-care because valid = 0.
- Minimum miss latencies, counted from the first stall cycle to the first cycle with cpu_stall_o = 0, with memory latency L = cycles from request to ack inclusive:
  - clean miss = L + 2 cycles;
  - dirty miss = 2L + 2 cycles.

Test Plan:
- Reset then lw 0x0000_0040 with memory ack after 10 cycles -> stall held 12 cycles; mem_addr_o = 0x40, mem_write_o = 0; cpu_data_o = word 0 of the fetched line; a second lw 0x44 hits with no stall.
- sw 0x0000_0048 data 0xDEADBEEF after line 0x40 is resident -> no stall; dirty[2] = 1; lw 0x48 returns 0xDEADBEEF.
- lw 0x0000_0240, which maps to the same index 2 with tag 1, after the dirty store -> WRITEBACK with mem_addr_o = 0x40 and word 2 of mem_data_o = 0xDEADBEEF; then FETCH with mem_addr_o = 0x240; stall = 2L + 2 cycles.
- Store miss to 0x0000_0080 data 0x12345678 -> fetch 0x80, merge the word, dirty[4] = 1; a subsequent eviction writes back a line containing 0x12345678.
- Assert rst_i low during FETCH, 3 cycles before ack -> mem_enable_o = 0 the same cycle and cpu_stall_o = 0; the late ack is ignored; a re-issued lw 0x40 misses again.
- Spurious mem_ack_i pulse in IDLE, and alternating hit/miss streams -> no state change on the spurious ack; mem_* outputs stay stable and unchanged during every wait.
